// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: requester ids, arbiter states and bus widths
// (the widths are also used by the bus decoder).
package cpu_bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  typedef enum logic {
    S_RR    = 1'b0,
    S_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector, purely combinational.
//   req[1:0] : request vector (bit 0 = CPU, bit 1 = DMA)
//   last     : 1 when DMA won the previous granted cycle
//   gnt_c    : one-hot grant (all zero when nothing requests)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_c
);

  // A lone requester wins; a tie goes to whoever did not win last.
  always_comb begin
    gnt_c = req;
    if (req == 2'b11) begin
      gnt_c = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the MEM stage (CPU)
// and the load/dump DMA port. One grant per cycle, 1-cycle read latency,
// bounded DMA burst lock.
//   clk, reset (async, active low)
//   cpu_*  : CPU request in, stall / read data / rvalid out
//   dma_*  : DMA request + lock in, grant / read data / rvalid out
//   mem_*  : memory strobe, write enable, address, data; mem_rdata back
module dmem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = BUS_ADDR_W,
  parameter int unsigned DATA_W    = BUS_DATA_W,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  req_id_e           last_q, last_d;
  logic              tag_vld_q, tag_vld_d;
  req_id_e           tag_id_q, tag_id_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic [1:0]        req_v;
  logic [1:0]        rr_gnt;
  logic [1:0]        win;

  // Requests are masked while reset is low so X inputs cannot leak through.
  assign req_v = {dma_req & reset, cpu_req & reset};

  rr_pick2 u_pick (
    .req   (req_v),
    .last  (last_q == REQ_DMA),
    .gnt_c (rr_gnt)
  );

  // Next state, burst counter and final winner.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    win     = rr_gnt;
    unique case (state_q)
      S_RR: begin
        if (win[1] && dma_lock) begin
          state_d = S_BURST;
          count_d = CNT_W'(1);
        end
      end
      S_BURST: begin
        if (!dma_lock || !req_v[1]) begin
          // Leaving the burst: this cycle falls back to round-robin.
          state_d = S_RR;
          count_d = '0;
        end else if (count_q < CNT_W'(MAX_BURST)) begin
          win     = 2'b10;
          count_d = count_q + CNT_W'(1);
        end else if (req_v[0]) begin
          // Budget spent: the CPU gets its one slot, burst continues.
          win     = 2'b01;
          count_d = '0;
        end else begin
          win = 2'b10;
        end
      end
      default: begin
        state_d = S_RR;
        count_d = '0;
      end
    endcase
  end

  // Memory port, handshakes, route tag and read-data capture.
  always_comb begin
    mem_en      = |win;
    mem_we      = (win[1] & dma_we) | (win[0] & cpu_we);
    mem_addr    = win[1] ? dma_addr : cpu_addr;
    mem_wdata   = win[1] ? dma_wdata : cpu_wdata;
    cpu_stall   = req_v[0] & ~win[0];
    dma_gnt     = req_v[1] & win[1];
    last_d      = last_q;
    if (|win) begin
      last_d = win[1] ? REQ_DMA : REQ_CPU;
    end
    tag_vld_d   = (|win) & ~mem_we;
    tag_id_d    = win[1] ? REQ_DMA : REQ_CPU;
    cpu_rvalid  = tag_vld_q && (tag_id_q == REQ_CPU);
    dma_rvalid  = tag_vld_q && (tag_id_q == REQ_DMA);
    // Read data passes through during the pulse and is held afterwards.
    cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    dma_rdata_d = dma_rvalid ? mem_rdata : dma_rdata_q;
    cpu_rdata   = cpu_rdata_d;
    dma_rdata   = dma_rdata_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RR;
      count_q     <= '0;
      last_q      <= REQ_DMA;
      tag_vld_q   <= 1'b0;
      tag_id_q    <= REQ_CPU;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      last_q      <= last_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule
